// File: rtl/timer_apb_sequencer.sv
// -----------------------------------------------------------------------------
// timer_apb_sequencer
//
// APB master that programs and services an 8-bit APB timer on its own.
// After an accepted start it writes the reload value (TDR, 0x00), loads it
// into the counter (TCR, 0x01, load bit set), starts the counter (TCR with
// load bit clear), then polls TSR (0x02).  Each poll that shows a flag is
// answered with a clearing write and counted as one event.  After the
// programmed number of events, on abort, or on a bus error, the timer is
// stopped by writing TCR=0x00.
//
// Handshake: an APB transfer is one SETUP cycle (psel=1, penable=0) followed
// by ACCESS cycles (psel=1, penable=1) until pready=1; address, direction and
// write data stay stable from SETUP to the cycle pready is seen, and every
// transfer is followed by at least one cycle with psel=0.
//
// Ports
//   pclk, presetn             clock, asynchronous active-low reset
//   start                     one-cycle start pulse (honoured in IDLE/DONE)
//   abort                     level; requests the stop sequence
//   cfg_tdr/cfg_tcr/num_events run configuration, sampled at start
//   busy, done, err           status (done is a one-cycle pulse, err sticky)
//   event_cnt, last_tsr       serviced event count, latest TSR value read
//   paddr..pwdata, prdata,
//   pready, pslverr           APB master port
//   dbg_state                 current FSM state, for observation only
// -----------------------------------------------------------------------------
module timer_apb_sequencer #(
   parameter int POLL_GAP  = 4,
   parameter int PREADY_TO = 16,
   parameter int ADDR_W    = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        cfg_tdr,
   input  logic [7:0]        cfg_tcr,
   input  logic [7:0]        num_events,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        event_cnt,
   output logic [7:0]        last_tsr,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [7:0]        pwdata,
   input  logic [7:0]        prdata,
   input  logic              pready,
   input  logic              pslverr,
   output logic [3:0]        dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_WR_TDR  = 4'd1,
      S_WR_LOAD = 4'd2,
      S_WR_RUN  = 4'd3,
      S_GAP     = 4'd4,
      S_POLL    = 4'd5,
      S_CLR     = 4'd6,
      S_STOP    = 4'd7,
      S_DONE    = 4'd8
   } state_t;

   // Phase of the transfer inside a bus state.  PH_IDLE is the quiet cycle
   // before SETUP; it is also where abort is sampled, so an in-flight
   // transfer is never cut short by abort.
   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_SETUP  = 2'd1,
      PH_ACCESS = 2'd2
   } phase_t;

   state_t      r_state, w_state_n;
   phase_t      r_phase, w_phase_n;
   logic [7:0]  r_tdr, r_tcr, r_num;
   logic [7:0]  r_evt, r_last;
   logic        r_err, r_done;
   logic [15:0] r_to_cnt, r_gap_cnt;

   logic        w_accept, w_set_err, w_cap_tsr, w_inc_evt;
   logic        w_gap_inc, w_to_inc, w_xfer;
   logic [7:0]  w_evt_inc;
   state_t      w_fail_dest, w_gap_dest;

   assign w_evt_inc   = (r_evt == 8'hFF) ? 8'hFF : r_evt + 8'd1;
   // An error while stopping cannot be recovered by stopping again.
   assign w_fail_dest = (r_state == S_STOP) ? S_DONE : S_STOP;
   // With no poll gap the next poll follows directly.
   assign w_gap_dest  = (POLL_GAP == 0) ? S_POLL : S_GAP;
   assign w_xfer      = (r_state == S_WR_TDR) || (r_state == S_WR_LOAD) ||
                        (r_state == S_WR_RUN) || (r_state == S_POLL)    ||
                        (r_state == S_CLR)    || (r_state == S_STOP);

   // ---------------- FSM state register ----------------
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state <= S_IDLE;
         r_phase <= PH_IDLE;
      end else begin
         r_state <= w_state_n;
         r_phase <= w_phase_n;
      end
   end

   // ---------------- FSM next state ----------------
   always_comb begin
      w_state_n = r_state;
      w_phase_n = r_phase;
      w_accept  = 1'b0;
      w_set_err = 1'b0;
      w_cap_tsr = 1'b0;
      w_inc_evt = 1'b0;
      w_gap_inc = 1'b0;
      w_to_inc  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_accept  = 1'b1;
               w_state_n = S_WR_TDR;
               w_phase_n = PH_IDLE;
            end
         end
         S_GAP: begin
            if (abort)
               w_state_n = S_STOP;
            else if (r_gap_cnt == 16'(POLL_GAP - 1))
               w_state_n = S_POLL;
            else
               w_gap_inc = 1'b1;
         end
         default: begin
            case (r_phase)
               PH_IDLE: begin
                  if (abort && (r_state != S_STOP))
                     w_state_n = S_STOP;
                  else
                     w_phase_n = PH_SETUP;
               end
               PH_SETUP: w_phase_n = PH_ACCESS;
               default: begin
                  if (pready) begin
                     w_phase_n = PH_IDLE;
                     if (pslverr) begin
                        w_set_err = 1'b1;
                        w_state_n = w_fail_dest;
                     end else begin
                        case (r_state)
                           S_WR_TDR:  w_state_n = S_WR_LOAD;
                           S_WR_LOAD: w_state_n = S_WR_RUN;
                           S_WR_RUN:  w_state_n = w_gap_dest;
                           S_POLL: begin
                              w_cap_tsr = 1'b1;
                              w_state_n = (prdata[1:0] != 2'b00) ? S_CLR : w_gap_dest;
                           end
                           S_CLR: begin
                              w_inc_evt = 1'b1;
                              w_state_n = ((r_num != 8'd0) && (w_evt_inc == r_num)) ?
                                          S_STOP : w_gap_dest;
                           end
                           S_STOP:    w_state_n = S_DONE;
                           default:   w_state_n = r_state;
                        endcase
                     end
                  end else if (r_to_cnt == 16'(PREADY_TO - 1)) begin
                     // Slave never answered: drop the transfer.
                     w_set_err = 1'b1;
                     w_phase_n = PH_IDLE;
                     w_state_n = w_fail_dest;
                  end else begin
                     w_to_inc = 1'b1;
                  end
               end
            endcase
         end
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_tdr     <= 8'd0;
         r_tcr     <= 8'd0;
         r_num     <= 8'd0;
         r_evt     <= 8'd0;
         r_last    <= 8'd0;
         r_err     <= 1'b0;
         r_done    <= 1'b0;
         r_to_cnt  <= 16'd0;
         r_gap_cnt <= 16'd0;
      end else begin
         r_done    <= (w_state_n == S_DONE) && (r_state != S_DONE);
         r_to_cnt  <= w_to_inc  ? r_to_cnt + 16'd1  : 16'd0;
         r_gap_cnt <= w_gap_inc ? r_gap_cnt + 16'd1 : 16'd0;
         if (w_accept) begin
            r_tdr <= cfg_tdr;
            r_tcr <= cfg_tcr;
            r_num <= num_events;
            r_evt <= 8'd0;
            r_err <= 1'b0;
         end
         if (w_set_err) r_err  <= 1'b1;
         if (w_cap_tsr) r_last <= prdata;
         if (w_inc_evt) r_evt  <= w_evt_inc;
      end
   end

   // ---------------- APB bus decode ----------------
   // Decoded from registers only, so asynchronous reset drops psel/penable
   // immediately.
   always_comb begin
      psel    = w_xfer && (r_phase != PH_IDLE);
      penable = w_xfer && (r_phase == PH_ACCESS);
      paddr   = '0;
      pwrite  = 1'b0;
      pwdata  = 8'h00;
      if (psel) begin
         case (r_state)
            S_WR_TDR:  begin paddr = ADDR_W'(0); pwrite = 1'b1; pwdata = r_tdr; end
            S_WR_LOAD: begin paddr = ADDR_W'(1); pwrite = 1'b1; pwdata = r_tcr | 8'h80; end
            S_WR_RUN:  begin paddr = ADDR_W'(1); pwrite = 1'b1; pwdata = r_tcr & 8'h7F; end
            S_POLL:    begin paddr = ADDR_W'(2); pwrite = 1'b0; end
            S_CLR:     begin paddr = ADDR_W'(2); pwrite = 1'b1; end
            S_STOP:    begin paddr = ADDR_W'(1); pwrite = 1'b1; end
            default:   begin paddr = '0;         pwrite = 1'b0; end
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done      = r_done;
   assign err       = r_err;
   assign event_cnt = r_evt;
   assign last_tsr  = r_last;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Testbench for timer_apb_sequencer: APB slave model with scripted TSR
// responses, a transaction scoreboard fed by a run-level reference model,
// table-driven scenarios, randomized runs and hand-written corner cases.
module tb_timer_apb_sequencer;
   localparam int POLL_GAP  = 4;
   localparam int PREADY_TO = 16;
   localparam int ADDR_W    = 8;

   // ---------------- clock / reset ----------------
   logic pclk = 1'b0;
   logic presetn = 1'b0;
   always #5 pclk = ~pclk;

   logic       start = 1'b0, abort = 1'b0;
   logic [7:0] cfg_tdr = 8'h00, cfg_tcr = 8'h00, num_events = 8'h00;
   logic       busy, done, err;
   logic [7:0] event_cnt, last_tsr;
   logic [ADDR_W-1:0] paddr;
   logic       psel, penable, pwrite;
   logic [7:0] pwdata;
   logic [7:0] prdata = 8'h00;
   logic       pready = 1'b0, pslverr = 1'b0;
   logic [3:0] dbg_state;

   timer_apb_sequencer #(.POLL_GAP(POLL_GAP), .PREADY_TO(PREADY_TO), .ADDR_W(ADDR_W)) dut (
      .pclk(pclk), .presetn(presetn), .start(start), .abort(abort),
      .cfg_tdr(cfg_tdr), .cfg_tcr(cfg_tcr), .num_events(num_events),
      .busy(busy), .done(done), .err(err), .event_cnt(event_cnt), .last_tsr(last_tsr),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr), .dbg_state(dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard entries: {pwrite, paddr, data} where data is pwdata or prdata.
   logic [16:0] exp_q[$];

   // Slave configuration
   int         s_miss = 0;       // empty polls before each flagged poll
   logic [1:0] s_flag = 2'b00;
   logic [5:0] s_upper = 6'h00;  // TSR upper bits (must be ignored by DUT)
   int         s_wait = 0;
   bit         s_rand_wait = 1'b0;
   int         s_err_sel = 0;    // 1: pslverr on TSR clear, 2: on TCR stop write
   bit         s_stuck = 1'b0;   // never answer the TCR load write
   bit         sb_en = 1'b0;
   int         poll_idx = 0, done_cnt = 0, drop_cnt = 0, drop_len = 0, clr_cnt = 0;

   function automatic logic [7:0] tsr_resp(input int k);
      return ((k % (s_miss + 1)) == s_miss) ? {s_upper, s_flag} : {s_upper, 2'b00};
   endfunction

   // ---------------- APB slave + protocol monitor ----------------
   initial begin
      logic p_psel, p_pen, p_rdy, p_wr;
      logic [7:0] p_addr, p_wd, rd;
      logic rdy, er;
      logic [16:0] obs;
      int acc, cw;
      p_psel = 0; p_pen = 0; p_rdy = 0; p_wr = 0; p_addr = 0; p_wd = 0; acc = 0; cw = 0;
      forever begin
         @(negedge pclk);
         if (done) done_cnt++;
         if (p_pen && p_rdy)
            check("idle_after_ready", {30'd0, psel, penable}, 32'd0);
         if (penable) begin
            check("penable_with_psel", psel, 1);
            if (p_pen && !p_rdy) begin
               check("access_stable", {paddr, pwrite, pwdata}, {p_addr, p_wr, p_wd});
               acc++;
            end else begin
               check("setup_then_access", {p_psel, p_pen, p_addr, p_wr, p_wd},
                     {2'b10, paddr, pwrite, pwdata});
               acc = 1;
               cw  = s_rand_wait ? $urandom_range(0, 3) : s_wait;
            end
            if (acc > PREADY_TO) check("access_len", acc, PREADY_TO);
         end else if (p_pen && !p_rdy && presetn) begin
            drop_cnt++;
            drop_len = acc;
         end
         rdy = 1'b0; er = 1'b0; rd = 8'h00;
         if (penable && acc > cw && !(s_stuck && paddr == 8'h01 && pwrite && pwdata[7])) begin
            rdy = 1'b1;
            if (!pwrite && paddr == 8'h02) begin
               rd = tsr_resp(poll_idx);
               poll_idx++;
            end
            er = (s_err_sel == 1 && pwrite && paddr == 8'h02) ||
                 (s_err_sel == 2 && pwrite && paddr == 8'h01 && pwdata == 8'h00);
            if (pwrite && paddr == 8'h02) clr_cnt++;
            if (sb_en) begin
               obs = {pwrite, paddr, pwrite ? pwdata : rd};
               if (exp_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_xfer: got %0h expected none", obs);
               end else begin
                  check("xfer", obs, exp_q.pop_front());
               end
            end
         end
         pready = rdy; pslverr = er; prdata = rd;
         p_psel = psel; p_pen = penable; p_rdy = rdy; p_wr = pwrite; p_addr = paddr; p_wd = pwdata;
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] tdr, tcr, num;
      int         miss;
      logic [1:0] flag;
      int         wait_cyc;
      int         err_sel;
      bit         stuck;
      logic [7:0] exp_evt;
      bit         exp_err;
   } vec_t;

   // Builds the expected bus transaction list of a whole run from the
   // programming rules, and the run's final status.
   task automatic build_model(input vec_t v, output logic [7:0] m_evt, output bit m_err,
                              output logic [7:0] m_last, output bit m_poll);
      logic [7:0] r;
      int cnt, k;
      m_evt = 0; m_err = 0; m_last = 0; m_poll = 0; cnt = 0; k = 0;
      exp_q.push_back({1'b1, 8'h00, v.tdr});
      if (v.stuck) begin
         m_err = 1;
      end else begin
         exp_q.push_back({1'b1, 8'h01, v.tcr | 8'h80});
         exp_q.push_back({1'b1, 8'h01, v.tcr & 8'h7F});
         while (k < 1000) begin
            r = tsr_resp(k);
            k++;
            exp_q.push_back({1'b0, 8'h02, r});
            m_last = r; m_poll = 1;
            if (r[1:0] != 2'b00) begin
               exp_q.push_back({1'b1, 8'h02, 8'h00});
               if (v.err_sel == 1) begin m_err = 1; break; end
               cnt++;
               if (cnt == int'(v.num)) break;
            end
         end
         if (v.err_sel == 2) m_err = 1;
      end
      exp_q.push_back({1'b1, 8'h01, 8'h00});
      m_evt = 8'(cnt);
   endtask

   // ---------------- driver tasks ----------------
   task automatic launch(input vec_t v, input logic [7:0] num_drive, output logic [7:0] m_evt,
                         output bit m_err, output logic [7:0] m_last, output bit m_poll);
      s_miss = v.miss; s_flag = v.flag; s_wait = v.wait_cyc; s_err_sel = v.err_sel;
      s_stuck = v.stuck; poll_idx = 0;
      exp_q.delete();
      build_model(v, m_evt, m_err, m_last, m_poll);
      @(negedge pclk);
      done_cnt = 0; drop_cnt = 0; sb_en = 1;
      cfg_tdr = v.tdr; cfg_tcr = v.tcr; num_events = num_drive; start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      // Configuration must have been captured at start.
      cfg_tdr = 8'($urandom); cfg_tcr = 8'($urandom); num_events = 8'($urandom);
      check("busy_after_start", busy, 1);
      check("evt_clr_on_start", event_cnt, 0);
      check("err_clr_on_start", err, 0);
   endtask

   task automatic finish_run(input string tag, input logic [7:0] e_evt, input bit e_err,
                             input logic [7:0] e_last, input bit e_poll);
      bit got;
      got = 0;
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge pclk);
         if (done) got = 1;
      end
      check({tag, "_done_seen"}, got, 1);
      repeat (4) @(negedge pclk);
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_err"}, err, e_err);
      check({tag, "_event_cnt"}, event_cnt, e_evt);
      check({tag, "_xfers_left"}, exp_q.size(), 0);
      if (e_poll) check({tag, "_last_tsr"}, last_tsr, e_last);
   endtask

   // ---------------- test sequence ----------------
   vec_t tbl[7];

   initial begin
      logic [7:0] m_evt, m_last;
      bit m_err, m_poll, got;
      vec_t v;

      tbl[0] = '{8'h00, 8'h30, 8'd1, 2, 2'd2, 0, 0, 1'b0, 8'd1, 1'b0}; // underflow
      tbl[1] = '{8'hFD, 8'h10, 8'd3, 1, 2'd1, 0, 0, 1'b0, 8'd3, 1'b0}; // overflow x3
      tbl[2] = '{8'h5A, 8'h31, 8'd2, 0, 2'd3, 5, 0, 1'b0, 8'd2, 1'b0}; // wait states
      tbl[3] = '{8'h12, 8'h10, 8'd1, 0, 2'd1, 0, 0, 1'b1, 8'd0, 1'b1}; // pready timeout
      tbl[4] = '{8'h40, 8'h30, 8'd2, 0, 2'd2, 0, 1, 1'b0, 8'd0, 1'b1}; // slverr on clear
      tbl[5] = '{8'h77, 8'h13, 8'd1, 0, 2'd1, 0, 2, 1'b0, 8'd1, 1'b1}; // slverr on stop
      tbl[6] = '{8'h00, 8'h10, 8'd2, 0, 2'd3, 1, 0, 1'b0, 8'd2, 1'b0}; // both flags

      // Reset state
      repeat (3) @(negedge pclk);
      check("reset_outputs", {busy, done, err, event_cnt, last_tsr, psel, penable, pwrite},
            32'd0);
      check("reset_bus", {paddr, pwdata}, 32'd0);
      presetn = 1'b1;
      // abort in IDLE does nothing
      abort = 1'b1;
      repeat (3) @(negedge pclk);
      check("idle_abort_busy", {busy, psel}, 32'd0);
      abort = 1'b0;

      // Table-driven scenarios
      for (int i = 0; i < 7; i++) begin
         launch(tbl[i], tbl[i].num, m_evt, m_err, m_last, m_poll);
         finish_run($sformatf("vec%0d", i), tbl[i].exp_evt, tbl[i].exp_err, m_last, m_poll);
         check($sformatf("vec%0d_model_evt", i), m_evt, tbl[i].exp_evt);
         if (tbl[i].stuck) begin
            check("timeout_len", drop_len, PREADY_TO);
            check("timeout_drops", drop_cnt, 1);
         end
      end

      // Randomized runs against the model
      s_rand_wait = 1'b1;
      for (int i = 0; i < 8; i++) begin
         v = '{8'($urandom), 8'($urandom), 8'($urandom_range(1, 4)), $urandom_range(0, 3),
               2'($urandom_range(1, 3)), 0, 0, 1'b0, 8'd0, 1'b0};
         s_upper = 6'($urandom);
         launch(v, v.num, m_evt, m_err, m_last, m_poll);
         finish_run($sformatf("rnd%0d", i), m_evt, m_err, m_last, m_poll);
      end
      s_rand_wait = 1'b0; s_upper = 6'h00;

      // Abort in GAP after two events; stray start while busy is ignored
      v = '{8'h20, 8'h10, 8'd2, 1, 2'd1, 0, 0, 1'b0, 8'd2, 1'b0};
      launch(v, 8'd0, m_evt, m_err, m_last, m_poll);
      repeat (3) @(negedge pclk);
      start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      got = 0;
      for (int c = 0; c < 2000 && !got; c++) begin
         @(negedge pclk);
         if (event_cnt == 8'd2 && dbg_state == 4'd4) got = 1;
      end
      check("abort_gap_reached", got, 1);
      abort = 1'b1;
      finish_run("abort", 8'd2, 1'b0, m_last, m_poll);
      abort = 1'b0;

      // Saturation with num_events = 0
      s_miss = 0; s_flag = 2'd1; s_wait = 0; s_err_sel = 0; s_stuck = 0; sb_en = 0;
      @(negedge pclk);
      clr_cnt = 0; done_cnt = 0;
      cfg_tdr = 8'h01; cfg_tcr = 8'h10; num_events = 8'd0; start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      got = 0;
      for (int c = 0; c < 5000 && !got; c++) begin
         @(negedge pclk);
         if (clr_cnt >= 258) got = 1;
      end
      check("sat_reached", got, 1);
      check("sat_event_cnt", event_cnt, 8'hFF);
      check("sat_busy", busy, 1);
      abort = 1'b1;
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge pclk);
         if (done) got = 1;
      end
      abort = 1'b0;
      check("sat_done", got, 1);
      check("sat_evt_after", event_cnt, 8'hFF);

      // Reset during POLL ACCESS
      s_wait = 12;
      @(negedge pclk);
      cfg_tdr = 8'h33; cfg_tcr = 8'h10; num_events = 8'd1; start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      got = 0;
      for (int c = 0; c < 500 && !got; c++) begin
         @(negedge pclk);
         if (psel && penable && paddr == 8'h02) got = 1;
      end
      check("poll_access_reached", got, 1);
      #2 presetn = 1'b0;
      #1;
      check("rst_async_bus", {psel, penable}, 32'd0);
      check("rst_async_busy", busy, 0);
      @(negedge pclk);
      presetn = 1'b1;
      s_wait = 0;
      launch(tbl[0], tbl[0].num, m_evt, m_err, m_last, m_poll);
      finish_run("after_rst", tbl[0].exp_evt, tbl[0].exp_err, m_last, m_poll);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/timer_apb_sequencer.md
Name: timer_apb_sequencer

Overview:
APB master that programs and services the 8-bit APB timer without CPU involvement. On a start pulse it performs these steps in order:
- writes the reload value to TDR (0x00);
- loads it into the counter through TCR (0x01);
- starts counting;
- polls TSR (0x02) for overflow/underflow and clears each flag it sees;
- stops the timer after a programmed number of events.
It sits between the system control logic and the timer's APB slave port, replacing the CPU bus model for autonomous interval generation.

Parameters:
POLL_GAP, 4, idle pclk cycles between consecutive TSR polls (0 = back-to-back)
PREADY_TO, 16, max ACCESS-phase cycles waiting for pready before abort with error
ADDR_W, 8, APB address width

Ports:
pclk  in  1  APB clock
presetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE/DONE, ignored otherwise
abort  in  1  level; forces STOP sequence from any non-IDLE state
cfg_tdr  in  8  reload value for TDR, sampled at start
cfg_tcr  in  8  run-mode TCR value (bit5 down, bit4 enable, bits1:0 clock select), sampled at start
num_events  in  8  flag events to service before stopping; 0 = run until abort
busy  out  1  high from accepted start until DONE
done  out  1  one-cycle pulse on entry to DONE
err  out  1  sticky; set on pslverr or pready timeout, cleared by next accepted start
event_cnt  out  8  serviced events, saturates at 8'hFF
last_tsr  out  8  TSR value from the most recent poll
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB write
pwdata  out  8  APB write data
prdata  in  8  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset values: all outputs 0; event_cnt=0, last_tsr=0; FSM in IDLE.
- Every APB transfer has two parts:
  - SETUP: one cycle, psel=1, penable=0, with paddr/pwrite/pwdata valid.
  - ACCESS: psel=1, penable=1, repeated until pready=1.
- Bus signals are held stable through ACCESS. psel and penable return to 0 the cycle after pready. No back-to-back ACCESS; at least one SETUP per transfer.
- FSM states:
  - IDLE / DONE: bus quiet. An accepted start latches cfg_tdr, cfg_tcr and num_events, clears event_cnt and err, and goes to WR_TDR.
  - WR_TDR: write cfg_tdr to 0x00.
  - WR_LOAD: write cfg_tcr|8'h80 to 0x01 (load bit set).
  - WR_RUN: write cfg_tcr&8'h7F to 0x01.
  - GAP: wait POLL_GAP cycles.
  - POLL: read 0x02; capture prdata into last_tsr at pready.
  - POLL exits to CLR if prdata[1:0]!=0, otherwise to GAP.
  - CLR: write 8'h00 to 0x02; event_cnt++ on its completion.
  - After CLR: go to STOP if num_events!=0 and the new count equals num_events; otherwise go to GAP.
  - STOP: write 8'h00 to 0x01, then go to DONE.
- Both flag bits set in one poll count as one event.
- event_cnt saturates at 255 when num_events=0.
- abort:
  - Sampled only between transfers; an in-flight transfer always completes.
  - From IDLE/DONE, abort has no effect.
  - abort during STOP is ignored.
- Errors:
  - pslverr=1 with pready, or pready timeout after PREADY_TO ACCESS cycles, sets err and jumps to STOP.
  - A timed-out transfer is dropped: psel=0 next cycle.
  - An error during STOP goes directly to DONE.
- busy is 1 in every state except IDLE/DONE.
- done fires exactly once per start.
- presetn low mid-transfer: psel and penable drop to 0 immediately (asynchronous); the timer itself is not stopped.

Test Plan:
- Underflow: cfg_tdr=8'h00, cfg_tcr=8'h30, num_events=1, timer counts 00→FF → writes in order (00←00), (01←B0), (01←30); polls read TSR with bit1=1, then (02←00), (01←00); event_cnt=1, done pulse, err=0.
- Overflow multi-event: cfg_tdr=8'hFD, cfg_tcr=8'h10, num_events=3 → three CLR writes; event_cnt=3; last_tsr[0]=1; exactly one done pulse.
- Wait states: slave holds pready low 5 cycles on every transfer, PREADY_TO=16 → signals stable through ACCESS; same write sequence; err=0.
- Timeout: pready stuck low on WR_LOAD → after 16 ACCESS cycles psel=0; err=1; STOP write attempted; done pulses; busy=0.
- Abort: num_events=0, assert abort during GAP after event_cnt=2 → next transfer is (01←00); event_cnt stays 2; done pulses.
- Reset mid-ACCESS: presetn low during POLL ACCESS → psel=penable=0 and busy=0 asynchronously; new start after release restarts from WR_TDR.
